div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Shares one sequential divider (start/ready/done handshake, W-bit dvnd/dvsr in, quo/rmd out) between N requesters.
- Round-robin arbitration over valid/ready request channels; sequences the divider's start pulse and captures its result on done.
- Returns the result on a single response channel tagged with the requester ID, with backpressure.
- Short-circuits divide-by-zero and guards against a hung divider with a watchdog.

Parameters:
- W, 8, operand/result width; must equal the divider's W.
- N, 4, number of requesters, 2..16.
- IDW, 2, requester ID width, ceil(log2(N)).
- TMO, 64, watchdog limit in cycles spent in WAIT.
- TW, 7, watchdog counter width, ceil(log2(TMO+1)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester accept; one-hot or zero.
- req_dvnd  in  N*W  flattened dividends; requester i uses bits [i*W +: W].
- req_dvsr  in  N*W  flattened divisors; same packing as req_dvnd.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_quo  out  W  quotient.
- rsp_rmd  out  W  remainder.
- rsp_dz  out  1  divide-by-zero flag.
- rsp_tmo  out  1  watchdog-timeout flag.
- div_start  out  1  single-cycle start pulse to the divider.
- div_dvnd  out  W  dividend to the divider.
- div_dvsr  out  W  divisor to the divider.
- div_ready  in  1  divider idle.
- div_done  in  1  divider completion pulse.
- div_quo  in  W  divider quotient.
- div_rmd  in  W  divider remainder.

Behaviour:
- Reset values (all outputs, asynchronous on rst=1):
  - req_ready=0, rsp_valid=0, div_start=0, rsp_dz=0, rsp_tmo=0.
  - rsp_id, rsp_quo, rsp_rmd, div_dvnd, div_dvsr all 0.
  - Round-robin pointer=0; FSM goes to ARB.
- Reset mid-operation: any in-flight request is dropped and no response is issued. The divider shares rst and is reset too.
- FSM states: ARB, ISSUE, WAIT, RESP.
- ARB:
  - If any req_valid and div_ready=1, grant g = first valid index at or after the pointer, searching upward with wrap-around.
  - Assert req_ready[g]=1 combinationally in that cycle. The transfer completes on that edge.
  - On that edge, latch operands into div_dvnd/div_dvsr, latch rsp_id=g, clear both flags.
  - If the latched dvsr=0: load rsp_quo=all-ones, rsp_rmd=dvnd, rsp_dz=1, and go to RESP. The divider is never started.
  - Otherwise go to ISSUE.
  - If div_ready=0, or there is no valid request, req_ready=0 and the FSM stays in ARB.
- ISSUE: div_start=1 for exactly one cycle with operands stable; clear the watchdog counter; go to WAIT.
- WAIT:
  - div_start=0.
  - On div_done=1, register rsp_quo=div_quo and rsp_rmd=div_rmd, then go to RESP.
  - Otherwise increment the watchdog counter. When it reaches TMO, load rsp_tmo=1, rsp_quo=0, rsp_rmd=0, and go to RESP.
  - If div_done and the timeout occur in the same cycle, div_done wins.
- RESP:
  - rsp_valid=1. rsp_* are held stable until rsp_ready=1.
  - Transfer happens on the edge where rsp_valid and rsp_ready are both 1. On that edge: pointer=(g+1) mod N, go to ARB.
- Latency and throughput:
  - Accept to div_start: 1 cycle.
  - div_done to rsp_valid: 1 cycle.
  - Divide-by-zero accept to rsp_valid: 1 cycle.
  - At most one request is outstanding; no request is accepted while in ISSUE, WAIT or RESP.
- Fairness: a continuously valid requester is granted within N grants.
- Operand rule: operands are sampled only at accept; later changes on req_dvnd/req_dvsr are ignored.
- Stray inputs: a div_done arriving outside WAIT is ignored.
- Arithmetic: unsigned only.

Test Plan:
- W=8, N=4. Requester 1 sends 100/7 -> div_start one cycle after accept with div_dvnd=100, div_dvsr=7. Response: rsp_id=1, quo=14, rmd=2, rsp_dz=0, rsp_tmo=0.
- All four requesters hold valid continuously with operands 200/3, 9/9, 5/8, 255/1 -> grant order 0,1,2,3,0. Results 66r2, 1r0, 0r5, 255r0.
- Requester 2 sends dvsr=0, dvnd=0x5A -> div_start never asserted. Response: rsp_dz=1, quo=0xFF, rmd=0x5A, one cycle after accept.
- Hold rsp_ready=0 for 10 cycles during RESP -> rsp_valid and rsp_* stay stable, req_ready stays 0 throughout. Exactly one transfer occurs when rsp_ready rises.
- Divider model never asserts div_done, TMO=64 -> rsp_valid after 64 WAIT cycles with rsp_tmo=1, quo=0, rmd=0. Arbitration resumes afterwards.
- Assert rst during WAIT -> all outputs reach reset values immediately and no response is issued. After release, requester 0 sends 17/5 -> quo=3, rmd=2.

Source files
------------

// File: rtl/div_share_arbiter_if.sv
// Request, response and divider-side signals of div_share_arbiter.
// The arbiter uses the slave view; the surrounding environment uses the master view.
interface div_share_arbiter_if #(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_dvnd;
    logic [N*W-1:0] req_dvsr;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_quo;
    logic [W-1:0]   rsp_rmd;
    logic           rsp_dz;
    logic           rsp_tmo;

    logic           div_start;
    logic [W-1:0]   div_dvnd;
    logic [W-1:0]   div_dvsr;
    logic           div_ready;
    logic           div_done;
    logic [W-1:0]   div_quo;
    logic [W-1:0]   div_rmd;

    modport slave (
        input  req_valid, req_dvnd, req_dvsr, rsp_ready,
               div_ready, div_done, div_quo, div_rmd,
        output req_ready, rsp_valid, rsp_id, rsp_quo, rsp_rmd, rsp_dz, rsp_tmo,
               div_start, div_dvnd, div_dvsr
    );

    modport master (
        output req_valid, req_dvnd, req_dvsr, rsp_ready,
               div_ready, div_done, div_quo, div_rmd,
        input  req_ready, rsp_valid, rsp_id, rsp_quo, rsp_rmd, rsp_dz, rsp_tmo,
               div_start, div_dvnd, div_dvsr
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one sequential divider between N requesters.
//
//   state | meaning
//   ARB   | waiting for a valid request while the divider is idle
//   ISSUE | one-cycle start pulse to the divider, watchdog loaded
//   WAIT  | divider busy; watchdog counts down towards a timeout
//   RESP  | result held on the response channel until accepted
//
// Divide-by-zero skips the divider and answers straight from ARB.
module div_share_arbiter #(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int TMO = 64,
    parameter int TW  = 7
) (
    input  logic               clk,
    input  logic               rst,
    div_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ARB, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt;
    logic           found;
    logic           accept;
    logic           wdog_tc;
    logic [W-1:0]   sel_dvnd;
    logic [W-1:0]   sel_dvsr;
    logic [TW-1:0]  wdog;
    int             srch_idx;

    // first valid requester at or after the pointer, wrapping past N-1
    always_comb begin
        found    = 1'b0;
        gnt      = '0;
        srch_idx = 0;
        for (int k = 0; k < N; k++) begin
            srch_idx = int'(ptr) + k;
            if (srch_idx >= N) srch_idx = srch_idx - N;
            if (!found && bus.req_valid[srch_idx]) begin
                found = 1'b1;
                gnt   = IDW'(srch_idx);
            end
        end
    end

    assign sel_dvnd = bus.req_dvnd[int'(gnt)*W +: W];
    assign sel_dvsr = bus.req_dvsr[int'(gnt)*W +: W];
    assign accept   = (state == ARB) && found && bus.div_ready;
    // the down-counter is loaded with TMO, so reaching 1 means TMO cycles spent in WAIT
    assign wdog_tc  = (wdog == TW'(1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB;
        else     state <= state_nxt;
    end

    // next-state decode and handshake strobes
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.div_start = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            ARB: begin
                if (accept) begin
                    bus.req_ready[gnt] = 1'b1;
                    state_nxt = (sel_dvsr == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                bus.div_start = 1'b1;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (bus.div_done || wdog_tc) state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    // operand capture, result capture, watchdog and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            wdog         <= '0;
            bus.div_dvnd <= '0;
            bus.div_dvsr <= '0;
            bus.rsp_id   <= '0;
            bus.rsp_quo  <= '0;
            bus.rsp_rmd  <= '0;
            bus.rsp_dz   <= 1'b0;
            bus.rsp_tmo  <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (accept) begin
                        bus.div_dvnd <= sel_dvnd;
                        bus.div_dvsr <= sel_dvsr;
                        bus.rsp_id   <= gnt;
                        bus.rsp_tmo  <= 1'b0;
                        if (sel_dvsr == '0) begin
                            bus.rsp_quo <= '1;
                            bus.rsp_rmd <= sel_dvnd;
                            bus.rsp_dz  <= 1'b1;
                        end else begin
                            bus.rsp_dz  <= 1'b0;
                        end
                    end
                end
                ISSUE: wdog <= TW'(TMO);
                WAIT: begin
                    if (bus.div_done) begin
                        bus.rsp_quo <= bus.div_quo;
                        bus.rsp_rmd <= bus.div_rmd;
                    end else if (wdog_tc) begin
                        bus.rsp_tmo <= 1'b1;
                        bus.rsp_quo <= '0;
                        bus.rsp_rmd <= '0;
                        wdog        <= '0;
                    end else begin
                        wdog <= wdog - TW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready)
                        ptr <= (bus.rsp_id == IDW'(N-1)) ? '0 : bus.rsp_id + IDW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter with a behavioural divider and
// a queue-based round-robin reference model.
module tb_div_share_arbiter;
    localparam int W = 8, N = 4, IDW = 2, TMO = 64, TW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_share_arbiter_if #(.W(W), .N(N), .IDW(IDW)) bus();

    div_share_arbiter #(.W(W), .N(N), .IDW(IDW), .TMO(TMO), .TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {logic [W-1:0] a; logic [W-1:0] b;} op_t;
    typedef struct {int id; int quo; int rmd; int dz; int tmo;} exp_t;
    typedef struct {int a; int b; int acc;} st_t;

    op_t  opq[N][$];
    exp_t sb[$];
    st_t  stq[$];
    int   glog[$];
    int   nchk = 0, nerr = 0, cyc = 0, mptr = 0, exp_due = 0, nxfer = 0, rdy_mode = 0;
    bit   hang = 0, kick = 0;

    task automatic chk(string name, int got, int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(string name);
        nchk++;
        nerr++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    task automatic push(int i, int a, int b);
        op_t o;
        o.a = W'(a);
        o.b = W'(b);
        opq[i].push_back(o);
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (sb.size() == 0);
        for (int i = 0; i < N; i++) if (opq[i].size() != 0) idle = 0;
        return idle;
    endfunction

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) fail_now("idle_timeout");
    endtask

    task automatic wait_rsp_valid(int budget);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) fail_now("rsp_valid_timeout");
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_div_start", bus.div_start, 0);
        chk("rst_rsp_dz",    bus.rsp_dz, 0);
        chk("rst_rsp_tmo",   bus.rsp_tmo, 0);
        chk("rst_rsp_id",    bus.rsp_id, 0);
        chk("rst_rsp_quo",   bus.rsp_quo, 0);
        chk("rst_rsp_rmd",   bus.rsp_rmd, 0);
        chk("rst_div_dvnd",  bus.div_dvnd, 0);
        chk("rst_div_dvsr",  bus.div_dvsr, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    // interval counter: cyc is the index of the clock period now in progress
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // requester drivers: each presents the head of its queue until accepted
    initial begin
        bus.req_valid = '0;
        bus.req_dvnd  = '0;
        bus.req_dvsr  = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!rst && opq[i].size() > 0) begin
                    bus.req_valid[i]        = 1'b1;
                    bus.req_dvnd[i*W +: W]  = opq[i][0].a;
                    bus.req_dvsr[i*W +: W]  = opq[i][0].b;
                end else begin
                    bus.req_valid[i]        = 1'b0;
                    bus.req_dvnd[i*W +: W]  = W'($urandom);
                    bus.req_dvsr[i*W +: W]  = W'($urandom);
                end
            end
        end
    end

    // response consumer readiness
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = ($urandom_range(0, 2) != 0);
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // behavioural divider with random latency; can be told to hang
    initial begin
        bit pend;
        int lat, da, db;
        st_t s;
        pend = 0; lat = 0; da = 0; db = 0;
        bus.div_ready = 1'b1;
        bus.div_done  = 1'b0;
        bus.div_quo   = '0;
        bus.div_rmd   = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.div_start) begin
                if (stq.size() == 0) begin
                    fail_now("div_start_unexpected");
                end else begin
                    s = stq.pop_front();
                    chk("div_dvnd", bus.div_dvnd, s.a);
                    chk("div_dvsr", bus.div_dvsr, s.b);
                    chk("start_latency", cyc, s.acc + 1);
                end
                pend = 1;
                lat  = $urandom_range(1, 5);
                da   = bus.div_dvnd;
                db   = bus.div_dvsr;
            end
            @(posedge clk); #1;
            if (rst) begin
                pend = 0;
                bus.div_ready = 1'b1;
                bus.div_done  = 1'b0;
            end else begin
                if (bus.div_done) begin
                    bus.div_done  = 1'b0;
                    bus.div_ready = 1'b1;
                end
                if (kick) begin
                    pend = 0;
                    kick = 0;
                    bus.div_ready = 1'b1;
                end
                if (pend) begin
                    bus.div_ready = 1'b0;
                    if (!hang) begin
                        lat--;
                        if (lat == 0) begin
                            bus.div_done = 1'b1;
                            bus.div_quo  = (db == 0) ? '1 : W'(da / db);
                            bus.div_rmd  = (db == 0) ? W'(da) : W'(da % db);
                            exp_due = cyc + 1;
                            pend = 0;
                        end
                    end
                end
            end
        end
    end

    // accept observer: round-robin reference model, pushes expected responses
    initial begin
        int g, exp_g, idx;
        bit exp_acc;
        op_t o;
        exp_t e;
        st_t s;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < N; i++) opq[i].delete();
                sb.delete();
                stq.delete();
                mptr = 0;
                continue;
            end
            chk("req_ready_onehot", int'($countones(bus.req_ready) <= 1), 1);
            exp_acc = (sb.size() == 0) && (|bus.req_valid) && bus.div_ready;
            chk("accept", int'(|bus.req_ready), int'(exp_acc));
            if (|bus.req_ready) begin
                g = 0;
                for (int i = 0; i < N; i++) if (bus.req_ready[i]) g = i;
                exp_g = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (mptr + k) % N;
                    if (exp_g < 0 && bus.req_valid[idx]) exp_g = idx;
                end
                chk("grant_id", g, exp_g);
                if (opq[g].size() == 0) begin
                    fail_now("grant_without_request");
                end else begin
                    o = opq[g].pop_front();
                    glog.push_back(g);
                    e.id = g; e.dz = 0; e.tmo = 0;
                    if (o.b == 0) begin
                        e.quo = 255; e.rmd = o.a; e.dz = 1;
                        exp_due = cyc + 1;
                    end else begin
                        if (hang) begin
                            e.quo = 0; e.rmd = 0; e.tmo = 1;
                            exp_due = cyc + 2 + TMO;
                        end else begin
                            e.quo = o.a / o.b; e.rmd = o.a % o.b;
                            exp_due = -1;
                        end
                        s.a = o.a; s.b = o.b; s.acc = cyc;
                        stq.push_back(s);
                    end
                    sb.push_back(e);
                end
            end
        end
    end

    // response monitor: compares the held response against the scoreboard head
    initial begin
        bit prev_v;
        exp_t e;
        prev_v = 0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                prev_v = 0;
                continue;
            end
            if (bus.rsp_valid) begin
                chk("req_ready_in_resp", bus.req_ready, 0);
                if (sb.size() == 0) begin
                    fail_now("spurious_rsp");
                end else begin
                    e = sb[0];
                    chk("rsp_id",  bus.rsp_id,  e.id);
                    chk("rsp_quo", bus.rsp_quo, e.quo);
                    chk("rsp_rmd", bus.rsp_rmd, e.rmd);
                    chk("rsp_dz",  bus.rsp_dz,  e.dz);
                    chk("rsp_tmo", bus.rsp_tmo, e.tmo);
                    if (!prev_v) chk("rsp_latency", cyc, exp_due);
                    if (bus.rsp_ready) begin
                        void'(sb.pop_front());
                        mptr = (e.id + 1) % N;
                        nxfer++;
                    end
                end
            end
            prev_v = bus.rsp_valid && !bus.rsp_ready;
        end
    end

    // stimulus sequence
    initial begin
        int exp_order[5];
        int n0, r, a, b;
        exp_order = '{0, 1, 2, 3, 0};

        do_reset();

        // all four requesters continuously valid
        glog.delete();
        push(0, 200, 3); push(1, 9, 9); push(2, 5, 8); push(3, 255, 1); push(0, 200, 3);
        wait_idle(1000);
        chk("grant_count", glog.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < glog.size()) chk($sformatf("grant_order_%0d", k), glog[k], exp_order[k]);

        // single request 100/7 from requester 1
        push(1, 100, 7);
        wait_idle(500);

        // divide by zero
        push(2, 8'h5A, 0);
        wait_idle(500);

        // response backpressure with a competing request pending
        rdy_mode = 2;
        n0 = nxfer;
        push(1, 40, 6);
        push(2, 33, 4);
        wait_rsp_valid(200);
        repeat (10) @(posedge clk);
        #2 rdy_mode = 0;
        wait_idle(500);
        chk("xfer_count", nxfer - n0, 2);

        // hung divider, then arbitration resumes
        hang = 1;
        push(3, 10, 3);
        wait_idle(500);
        hang = 0;
        kick = 1;
        push(0, 77, 7);
        wait_idle(500);

        // reset while waiting on the divider
        hang = 1;
        push(3, 50, 5);
        repeat (6) @(posedge clk);
        hang = 0;
        do_reset();
        push(0, 17, 5);
        wait_idle(500);

        // randomized traffic with random backpressure
        rdy_mode = 1;
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, N-1);
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            push(r, a, b);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        wait_idle(5000);
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
